// File: rtl/console_renderer_pkg.sv
// Shared definitions for the text-mode console renderer: attribute layout,
// RGB333 component levels and the colour expansion helpers.
package console_renderer_pkg;

    localparam logic [2:0] RGB_OFF  = 3'b000;
    localparam logic [2:0] RGB_MID  = 3'b101;
    localparam logic [2:0] RGB_FULL = 3'b111;

    // Attribute byte as stored in the upper half of a char RAM word.
    typedef struct packed {
        logic       blink;
        logic [2:0] bg;
        logic       intensity;
        logic [2:0] fg;
    } attr_t;

    function automatic logic [2:0] expand(input logic set, input logic bright);
        logic [2:0] level;
        if (!set) begin
            level = RGB_OFF;
        end else if (bright) begin
            level = RGB_FULL;
        end else begin
            level = RGB_MID;
        end
        return level;
    endfunction

    function automatic logic [8:0] fg_colour(input attr_t a);
        return {expand(a.fg[2], a.intensity), expand(a.fg[1], a.intensity),
                expand(a.fg[0], a.intensity)};
    endfunction

    function automatic logic [8:0] bg_colour(input attr_t a);
        return {expand(a.bg[2], 1'b0), expand(a.bg[1], 1'b0), expand(a.bg[0], 1'b0)};
    endfunction

endpackage

// File: rtl/console_blink.sv
// Frame-tick detection and blink phase generation. A frame starts on the
// first sample of (0,0); the phase toggles every BLINK_FRAMES frames.
module console_blink #(
    parameter int BLINK_FRAMES = 30
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [9:0] x,
    input  logic [9:0] y,
    output logic       blink_phase
);

    localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [CNT_W-1:0] count_d, count_q;
    logic             phase_d, phase_q;
    logic             prev_origin_d, prev_origin_q;
    logic             at_origin_s;

    // Next-state for the frame counter and blink phase.
    always_comb begin
        at_origin_s   = (x == 10'd0) && (y == 10'd0);
        prev_origin_d = at_origin_s;
        count_d       = count_q;
        phase_d       = phase_q;
        if (at_origin_s && !prev_origin_q) begin
            if (count_q == LAST) begin
                count_d = '0;
                phase_d = ~phase_q;
            end else begin
                count_d = count_q + CNT_W'(1);
            end
        end else begin
            count_d = count_q;
        end
    end

    // Blink state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q       <= '0;
            phase_q       <= 1'b1;
            prev_origin_q <= 1'b0;
        end else begin
            count_q       <= count_d;
            phase_q       <= phase_d;
            prev_origin_q <= prev_origin_d;
        end
    end

    assign blink_phase = phase_q;

endmodule

// File: rtl/console_renderer.sv
// Text-mode renderer: pixel -> cell -> char RAM -> font ROM -> RGB333,
// a fixed four-stage pipeline with per-cell colours, blink and cursor.
module console_renderer
    import console_renderer_pkg::*;
#(
    parameter int COLS         = 80,
    parameter int ROWS         = 30,
    parameter int CHAR_W       = 8,
    parameter int CHAR_H       = 16,
    parameter int CHAR_AW      = 13,
    parameter int FONT_AW      = 12,
    parameter int BLINK_FRAMES = 30
) (
    input  logic               vgaClock,
    input  logic               rst,
    input  logic [9:0]         x,
    input  logic [9:0]         y,
    input  logic               active,
    input  logic               cursorEn,
    input  logic [6:0]         cursorCol,
    input  logic [4:0]         cursorRow,
    output logic [CHAR_AW-1:0] addrRChar,
    input  logic [15:0]        dataChar,
    output logic [FONT_AW-1:0] addrRFont,
    input  logic [7:0]         dataFont,
    output logic [8:0]         pixelData,
    output logic               pixelValid
);

    localparam int XS     = (CHAR_W > 1) ? $clog2(CHAR_W) : 0;
    localparam int YS     = (CHAR_H > 1) ? $clog2(CHAR_H) : 0;
    localparam int LINE_W = (YS > 0) ? YS : 1;

    logic [9:0]        col_s, row_s;
    logic [2:0]        bit_s;
    logic [LINE_W-1:0] line_s;
    logic              in_range_s, cursor_hit_s, blink_phase_s;
    logic              glyph_on_s, cursor_on_s;

    logic               v1_d, v1_q, v2_d, v2_q, v3_d, v3_q;
    logic [2:0]         bit1_d, bit1_q, bit2_d, bit2_q, bit3_d, bit3_q;
    logic [LINE_W-1:0]  line1_d, line1_q, line2_d, line2_q;
    logic               cur1_d, cur1_q, cur2_d, cur2_q, cur3_d, cur3_q;
    logic [15:0]        char_word_d, char_word_q;
    attr_t              attr3_d, attr3_q;
    logic [CHAR_AW-1:0] addr_r_char_d, addr_r_char_q;
    logic [FONT_AW-1:0] addr_r_font_d, addr_r_font_q;
    logic [8:0]         pixel_data_d, pixel_data_q;
    logic               pixel_valid_d, pixel_valid_q;

    console_blink #(.BLINK_FRAMES(BLINK_FRAMES)) u_blink (
        .clk         (vgaClock),
        .rst         (rst),
        .x           (x),
        .y           (y),
        .blink_phase (blink_phase_s)
    );

    // Cell decode of the incoming pixel position.
    always_comb begin
        col_s        = x >> XS;
        row_s        = y >> YS;
        bit_s        = 3'(x & 10'(CHAR_W - 1));
        line_s       = LINE_W'(y & 10'(CHAR_H - 1));
        in_range_s   = active && (col_s < 10'(COLS)) && (row_s < 10'(ROWS));
        cursor_hit_s = cursorEn && (col_s == {3'b000, cursorCol})
                       && (row_s == {5'b00000, cursorRow})
                       && (line_s >= LINE_W'(CHAR_H - 2));
    end

    // Address generation and side-band alignment for stages 1-3.
    always_comb begin
        v1_d    = in_range_s;
        bit1_d  = bit_s;
        line1_d = line_s;
        cur1_d  = cursor_hit_s;
        addr_r_char_d = addr_r_char_q;
        if (in_range_s) begin
            addr_r_char_d = CHAR_AW'(row_s) * CHAR_AW'(COLS) + CHAR_AW'(col_s);
        end else begin
            addr_r_char_d = addr_r_char_q;
        end
        // The char word is registered once so the font multiply-add starts from a flop.
        v2_d        = v1_q;
        bit2_d      = bit1_q;
        line2_d     = line1_q;
        cur2_d      = cur1_q;
        char_word_d = dataChar;
        v3_d          = v2_q;
        bit3_d        = bit2_q;
        cur3_d        = cur2_q;
        attr3_d       = attr_t'(char_word_q[15:8]);
        addr_r_font_d = FONT_AW'(char_word_q[7:0]) * FONT_AW'(CHAR_H) + FONT_AW'(line2_q);
    end

    // Final colour selection from glyph row, attribute, blink and cursor.
    always_comb begin
        glyph_on_s    = dataFont[3'd7 - bit3_q] & ~(attr3_q.blink & ~blink_phase_s);
        cursor_on_s   = cur3_q & blink_phase_s;
        pixel_valid_d = v3_q;
        if (!v3_q) begin
            pixel_data_d = 9'd0;
        end else if (glyph_on_s || cursor_on_s) begin
            pixel_data_d = fg_colour(attr3_q);
        end else begin
            pixel_data_d = bg_colour(attr3_q);
        end
    end

    // Pipeline registers.
    always_ff @(posedge vgaClock) begin
        if (rst) begin
            v1_q <= 1'b0; v2_q <= 1'b0; v3_q <= 1'b0;
            bit1_q <= 3'd0; bit2_q <= 3'd0; bit3_q <= 3'd0;
            line1_q <= '0; line2_q <= '0;
            cur1_q <= 1'b0; cur2_q <= 1'b0; cur3_q <= 1'b0;
            char_word_q   <= 16'd0;
            attr3_q       <= '0;
            addr_r_char_q <= '0;
            addr_r_font_q <= '0;
            pixel_data_q  <= 9'd0;
            pixel_valid_q <= 1'b0;
        end else begin
            v1_q <= v1_d; v2_q <= v2_d; v3_q <= v3_d;
            bit1_q <= bit1_d; bit2_q <= bit2_d; bit3_q <= bit3_d;
            line1_q <= line1_d; line2_q <= line2_d;
            cur1_q <= cur1_d; cur2_q <= cur2_d; cur3_q <= cur3_d;
            char_word_q   <= char_word_d;
            attr3_q       <= attr3_d;
            addr_r_char_q <= addr_r_char_d;
            addr_r_font_q <= addr_r_font_d;
            pixel_data_q  <= pixel_data_d;
            pixel_valid_q <= pixel_valid_d;
        end
    end

    assign addrRChar  = addr_r_char_q;
    assign addrRFont  = addr_r_font_q;
    assign pixelData  = pixel_data_q;
    assign pixelValid = pixel_valid_q;

endmodule

// File: tb/tb_console_renderer.sv
// Self-checking bench: memory models, a blink/pixel reference model and a
// scoreboard pairing each sample with the output three edges later.
module tb_console_renderer;

    logic        clk = 1'b0;
    logic        rst, active, cursorEn;
    logic [9:0]  x, y;
    logic [6:0]  cursorCol;
    logic [4:0]  cursorRow;
    logic [12:0] addrRChar;
    logic [15:0] dataChar;
    logic [11:0] addrRFont;
    logic [7:0]  dataFont;
    logic [8:0]  pixelData;
    logic        pixelValid;

    logic [15:0] char_mem [0:8191];
    logic [7:0]  font_mem [0:4095];

    int checks = 0;
    int failures = 0;

    int m_count;
    bit m_phase;
    bit m_prev_origin;
    logic [9:0] exp_q[$];
    logic [9:0] act_q[$];

    always #5 clk = ~clk;

    assign dataChar = char_mem[addrRChar];
    assign dataFont = font_mem[addrRFont];

    console_renderer #(.BLINK_FRAMES(2)) dut (
        .vgaClock(clk), .rst(rst), .x(x), .y(y), .active(active),
        .cursorEn(cursorEn), .cursorCol(cursorCol), .cursorRow(cursorRow),
        .addrRChar(addrRChar), .dataChar(dataChar),
        .addrRFont(addrRFont), .dataFont(dataFont),
        .pixelData(pixelData), .pixelValid(pixelValid)
    );

    function automatic logic [2:0] comp(input bit set, input bit bright);
        return set ? (bright ? 3'b111 : 3'b101) : 3'b000;
    endfunction

    function automatic logic [9:0] model_pixel(input int px, input int py, input bit act,
                                               input bit cen, input int ccol, input int crow,
                                               input bit phase);
        int col, row, line, bitn;
        logic [15:0] w;
        logic [7:0] g, a;
        logic [8:0] fg, bg;
        bit on, cur;
        col = px / 8; row = py / 16; line = py % 16; bitn = px % 8;
        if (!(act && col < 80 && row < 30)) return 10'd0;
        w = char_mem[row * 80 + col];
        g = font_mem[w[7:0] * 16 + line];
        a = w[15:8];
        on = g[7 - bitn];
        if (a[7] && !phase) on = 1'b0;
        cur = cen && col == ccol && row == crow && line >= 14 && phase;
        fg = {comp(a[2], a[3]), comp(a[1], a[3]), comp(a[0], a[3])};
        bg = {comp(a[6], 1'b0), comp(a[5], 1'b0), comp(a[4], 1'b0)};
        return {1'b1, (on || cur) ? fg : bg};
    endfunction

    task automatic drive(input int px, input int py, input bit act, input bit do_rst);
        bit origin;
        rst = do_rst; x = 10'(px); y = 10'(py); active = act;
        if (do_rst) begin
            m_count = 0; m_phase = 1'b1; m_prev_origin = 1'b0;
            for (int i = exp_q.size() - 3; i < exp_q.size(); i++)
                if (i >= 0) exp_q[i] = 10'd0;
            exp_q.push_back(10'd0);
        end else begin
            origin = (px == 0) && (py == 0);
            if (origin && !m_prev_origin) begin
                if (m_count == 1) begin m_count = 0; m_phase = !m_phase; end
                else m_count++;
            end
            m_prev_origin = origin;
            exp_q.push_back(model_pixel(px, py, act, cursorEn, int'(cursorCol),
                                        int'(cursorRow), m_phase));
        end
        @(posedge clk); #1;
        act_q.push_back({pixelValid, pixelData});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(700, 500, 1'b0, 1'b0);
    endtask

    task automatic test_reset;
        drive(700, 500, 1'b0, 1'b1);
        drive(700, 500, 1'b0, 1'b1);
        checks++; if (addrRChar !== 13'd0) begin failures++; $display("FAIL reset_addr_char got=%0d exp=0", addrRChar); end
        checks++; if (addrRFont !== 12'd0) begin failures++; $display("FAIL reset_addr_font got=%0d exp=0", addrRFont); end
        checks++; if (pixelValid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", pixelValid); end
        checks++; if (pixelData !== 9'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", pixelData); end
        idle(3);
        while (act_q.size() > 0) begin
            logic [9:0] a, e;
            a = act_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (a !== e) begin failures++; $display("FAIL reset_stream got=%h exp=%h", a, e); end
        end
    endtask

    task automatic test_address;
        char_mem[162] = 16'h0741;
        font_mem[1043] = 8'h80;
        drive(17, 35, 1'b1, 1'b0);
        checks++; if (addrRChar !== 13'd162) begin failures++; $display("FAIL addr_char got=%0d exp=162", addrRChar); end
        idle(2);
        checks++; if (addrRFont !== 12'd1043) begin failures++; $display("FAIL addr_font got=%0d exp=1043", addrRFont); end
        idle(2);
        while (act_q.size() > 0) begin
            logic [9:0] a, e;
            a = act_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (a !== e) begin failures++; $display("FAIL address_pixel got=%h exp=%h", a, e); end
        end
    endtask

    task automatic test_colour;
        char_mem[162] = 16'h1F41;
        drive(16, 35, 1'b1, 1'b0);
        drive(17, 35, 1'b1, 1'b0);
        idle(3);
        checks++; if (act_q[2] !== 10'h000) begin failures++; $display("FAIL colour_latency got=%h exp=000", act_q[2]); end
        checks++; if (act_q[3] !== {1'b1, 9'h1FF}) begin failures++; $display("FAIL colour_fg got=%h exp=3ff", act_q[3]); end
        checks++; if (act_q[4] !== {1'b1, 9'h005}) begin failures++; $display("FAIL colour_bg got=%h exp=205", act_q[4]); end
        while (act_q.size() > 0) begin
            logic [9:0] a, e;
            a = act_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (a !== e) begin failures++; $display("FAIL colour_pixel got=%h exp=%h", a, e); end
        end
    endtask

    task automatic test_range;
        drive(17, 35, 1'b1, 1'b0);
        drive(640, 35, 1'b1, 1'b0);
        checks++; if (addrRChar !== 13'd162) begin failures++; $display("FAIL range_col80_hold got=%0d exp=162", addrRChar); end
        drive(17, 35, 1'b0, 1'b0);
        checks++; if (addrRChar !== 13'd162) begin failures++; $display("FAIL range_inactive_hold got=%0d exp=162", addrRChar); end
        drive(639, 479, 1'b1, 1'b0);
        checks++; if (addrRChar !== 13'd2399) begin failures++; $display("FAIL range_last_cell got=%0d exp=2399", addrRChar); end
        drive(100, 480, 1'b1, 1'b0);
        checks++; if (addrRChar !== 13'd2399) begin failures++; $display("FAIL range_row30_hold got=%0d exp=2399", addrRChar); end
        idle(3);
        while (act_q.size() > 0) begin
            logic [9:0] a, e;
            a = act_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (a !== e) begin failures++; $display("FAIL range_pixel got=%h exp=%h", a, e); end
        end
    endtask

    task automatic test_cursor;
        char_mem[162] = 16'h1F42;
        char_mem[163] = 16'h1F42;
        cursorEn = 1'b1; cursorCol = 7'd2; cursorRow = 5'd2;
        for (int line = 0; line < 16; line++) drive(17, 32 + line, 1'b1, 1'b0);
        drive(25, 46, 1'b1, 1'b0);
        idle(3);
        for (int line = 0; line < 16; line++) begin
            logic [9:0] want;
            want = (line >= 14) ? {1'b1, 9'h1FF} : {1'b1, 9'h005};
            checks++;
            if (act_q[3 + line] !== want) begin
                failures++; $display("FAIL cursor_line%0d got=%h exp=%h", line, act_q[3 + line], want);
            end
        end
        while (act_q.size() > 0) begin
            logic [9:0] a, e;
            a = act_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (a !== e) begin failures++; $display("FAIL cursor_pixel got=%h exp=%h", a, e); end
        end
        cursorEn = 1'b0;
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 2400; i++) char_mem[i] = 16'($urandom);
        for (int i = 0; i < 4096; i++) font_mem[i] = 8'($urandom);
        for (int i = 0; i < 60; i++) begin
            int px, py;
            px = int'($urandom_range(8, 660));
            py = int'($urandom_range(16, 495));
            cursorEn  = 1'($urandom_range(0, 1));
            cursorCol = 7'(px / 8);
            cursorRow = 5'(py / 16);
            drive(px, py, 1'($urandom_range(0, 3) != 0), 1'b0);
        end
        cursorEn = 1'b0;
        idle(3);
        while (act_q.size() > 0) begin
            logic [9:0] a, e;
            a = act_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (a !== e) begin failures++; $display("FAIL stream_pixel got=%h exp=%h", a, e); end
        end
    endtask

    task automatic test_blink;
        drive(700, 500, 1'b0, 1'b1);
        char_mem[162] = 16'h8741;
        font_mem[1043] = 8'hFF;
        for (int f = 0; f < 6; f++) begin
            drive(17, 35, 1'b1, 1'b0);
            idle(3);
            drive(0, 0, 1'b0, 1'b0);
        end
        idle(3);
        for (int f = 0; f < 6; f++) begin
            logic [9:0] want;
            want = (f < 2 || f >= 4) ? {1'b1, 9'h16D} : {1'b1, 9'h000};
            checks++;
            if (act_q[1 + 5 * f + 3] !== want) begin
                failures++; $display("FAIL blink_frame%0d got=%h exp=%h", f, act_q[1 + 5 * f + 3], want);
            end
        end
        while (act_q.size() > 0) begin
            logic [9:0] a, e;
            a = act_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (a !== e) begin failures++; $display("FAIL blink_pixel got=%h exp=%h", a, e); end
        end
    endtask

    task automatic test_reset_midstream;
        for (int i = 0; i < 12; i++) drive(16 + (i % 8), 35, 1'b1, i == 5);
        idle(3);
        for (int i = 5; i < 9; i++) begin
            checks++;
            if (act_q[i] !== 10'h000) begin failures++; $display("FAIL midreset_quiet%0d got=%h exp=000", i - 5, act_q[i]); end
        end
        checks++; if (act_q[9] !== {1'b1, 9'h16D}) begin failures++; $display("FAIL midreset_resume got=%h exp=36d", act_q[9]); end
        while (act_q.size() > 0) begin
            logic [9:0] a, e;
            a = act_q.pop_front(); e = exp_q.pop_front(); checks++;
            if (a !== e) begin failures++; $display("FAIL midreset_pixel got=%h exp=%h", a, e); end
        end
    endtask

    initial begin
        rst = 1'b1; x = 10'd700; y = 10'd500; active = 1'b0;
        cursorEn = 1'b0; cursorCol = 7'd0; cursorRow = 5'd0;
        for (int i = 0; i < 8192; i++) char_mem[i] = 16'h0000;
        for (int i = 0; i < 4096; i++) font_mem[i] = 8'h00;
        m_count = 0; m_phase = 1'b1; m_prev_origin = 1'b0;
        for (int i = 0; i < 3; i++) exp_q.push_back(10'd0);
        test_reset();
        test_address();
        test_colour();
        test_range();
        test_cursor();
        test_back_to_back();
        test_blink();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
